fifo_out: RTL and testbench
===========================

Name: fifo_out

Overview:
Transmit-side FIFO that sits directly downstream of top_level_block.
- Accepts 128-bit AES result blocks (dataPacketOut) in one write.
- Returns them as 32-bit words, most significant word first, for the outbound bus interface.
- Mirror image of fifo_in: a block written here as 128'hA_B_C_D leaves as words A, B, C, D.

Parameters:
DEPTH, 2, number of 128-bit entries; power of 2, minimum 2
ADDR_W, $clog2(DEPTH), entry pointer width; localparam, not overridable

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
write_en  input  1  push one 128-bit block
data_in  input  128  block to push; [127:96] is the first word out
read_en  input  1  pop one 32-bit word
data_out  output  32  head word, first-word-fall-through
fifo_empty  output  1  no words available
fifo_full  output  1  all DEPTH entries occupied
words_avail  output  $clog2(4*DEPTH)+1  count of 32-bit words readable

Behaviour:
- Storage is a DEPTH x 128 register array. Storage is not reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide, with the MSB used as the wrap bit.
  - word_sel is a 2-bit index into the head entry.
- Reset, applied asynchronously: wr_ptr=0, rd_ptr=0, word_sel=0. As a result fifo_empty=1, fifo_full=0, data_out=0, words_avail=0.
- Flags are combinational from registered pointers:
  - fifo_empty = (wr_ptr == rd_ptr).
  - fifo_full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]).
- words_avail = 4*(wr_ptr - rd_ptr) - word_sel, computed modulo 2^(ADDR_W+1) before scaling.
- data_out = mem[rd_ptr[ADDR_W-1:0]][127-32*word_sel -: 32] when not empty, else 32'h0.
- Write: at posedge, if write_en && !fifo_full, then mem[wr_ptr] <= data_in and wr_ptr++.
  - Visible on flags and data_out the cycle after the edge.
  - Write while full is dropped with no state change.
- Read: at posedge, if read_en && !fifo_empty:
  - word_sel == 3: word_sel <= 0 and rd_ptr++ (entry freed).
  - otherwise: word_sel++.
  - Read while empty is ignored.
- Simultaneous write and read:
  - Both are evaluated against pre-edge flags.
  - When full, the write is dropped even if the read frees the entry on the same edge.
  - When empty, the read is ignored and the write is accepted.
  - Otherwise both take effect.
- Wrap-around: pointers increment modulo 2^(ADDR_W+1); no special case is needed.
- Reset mid-drain discards all entries and any partially read entry. data_out is 0 from the reset assertion onward.
- Latency: written block's first word appears on data_out 1 cycle after the accepting edge.
- Throughput: 1 word/cycle sustained.

Optional Feature:
Macro: FIFO_OUT_ERR_EN
- Defined: adds outputs overflow (1) and underflow (1).
  - overflow is a sticky flag, set on an edge where write_en && fifo_full.
  - underflow is a sticky flag, set on an edge where read_en && fifo_empty.
  - Both are cleared only by n_rst; reset value is 0.
- Undefined: both ports and their logic are absent, and dropped operations are silent.

Decomposition:
- Package aes_fifo_pkg: WORD_W=32, BLOCK_W=128, WORDS_PER_BLOCK=4, and typedef word_t (logic [31:0]), block_t (logic [127:0]).
- fifo_in adopts the same package.
- One natural sub-module: fifo_ptr_ctrl, holding the wrap-bit pointer pair and full/empty logic. Parameterised by ADDR_W and shareable with fifo_in.
- Word selection and the data path stay in fifo_out.

Test Plan:
- Reset: hold n_rst=0 mid-cycle -> fifo_empty=1, fifo_full=0, data_out=32'h0, words_avail=0 without a clock edge.
- Single block: write 128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D.
  - Next cycle: data_out=32'h7D8AE0F7 and words_avail=4.
  - Reads on 4 consecutive edges: data_out becomes 32'hCFA0A6CB, then 32'h09FB5D05, then 32'hA8EC586D, after which fifo_empty=1.
- Fill (DEPTH=2): write 128'hdeb0f81341f3503a7cd01e2bc7cdd556, then 128'hE6FEBF30133874EBCB49226CD36D0D4F -> fifo_full=1 and words_avail=8.
  - A third write of 128'h67928dd5470d4a11f0ea4ae7d49b2dd4 is dropped.
  - Draining yields exactly 8 words, starting 32'hdeb0f813 and ending 32'hD36D0D4F.
- Simultaneous events, full: write_en=1 and read_en=1 on the edge that pops the 4th word of entry 0 -> write dropped, fifo_full=0 afterwards, words_avail=4.
- Simultaneous events, empty: write_en=1 and read_en=1 -> write accepted, read ignored, words_avail=4.
- Wrap-around and reset mid-drain:
  - Perform 5 write/drain cycles of distinct blocks -> every word comes out in order across pointer wrap.
  - Assert n_rst after 2 of 4 words -> empty, and the subsequent block reads out from its first word.
- With FIFO_OUT_ERR_EN:
  - read_en on empty -> underflow=1, which stays 1 after valid traffic.
  - write_en on full -> overflow=1.
  - n_rst clears both.

Source files
------------

// File: rtl/aes_fifo_pkg.sv
// Shared widths and types for the AES block/word FIFOs (fifo_in, fifo_out).
package aes_fifo_pkg;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/fifo_out_if.sv
// Block-in / word-out bus bundle for fifo_out; FIFO_OUT_ERR_EN adds sticky error flags.
interface fifo_out_if #(
  parameter int DEPTH = 2
);
  import aes_fifo_pkg::*;

  localparam int AVAIL_W = $clog2(4 * DEPTH) + 1;

  logic               write_en;
  block_t             data_in;
  logic               read_en;
  word_t              data_out;
  logic               fifo_empty;
  logic               fifo_full;
  logic [AVAIL_W-1:0] words_avail;
`ifdef FIFO_OUT_ERR_EN
  logic               overflow;
  logic               underflow;

  modport master (
    output write_en, data_in, read_en,
    input  data_out, fifo_empty, fifo_full, words_avail, overflow, underflow
  );
  modport slave (
    input  write_en, data_in, read_en,
    output data_out, fifo_empty, fifo_full, words_avail, overflow, underflow
  );
`else
  modport master (
    output write_en, data_in, read_en,
    input  data_out, fifo_empty, fifo_full, words_avail
  );
  modport slave (
    input  write_en, data_in, read_en,
    output data_out, fifo_empty, fifo_full, words_avail
  );
`endif
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Wrap-bit read/write pointer pair with full/empty flags; shared by fifo_in and fifo_out.
module fifo_ptr_ctrl #(
  parameter int ADDR_W = 1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            wr_inc,
  input  logic            rd_inc,
  output logic [ADDR_W:0] wr_ptr,
  output logic [ADDR_W:0] rd_ptr,
  output logic            empty,
  output logic            full
);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_inc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_inc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Same index with differing wrap bits means the writer is one full lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
endmodule

// File: rtl/fifo_out.sv
// 128-bit block in, 32-bit words out MSW first, first-word-fall-through, 1 cycle write-to-read.
// Optional FIFO_OUT_ERR_EN adds sticky overflow/underflow flags; otherwise dropped ops are silent.
module fifo_out
  import aes_fifo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  fifo_out_if.slave  bus
);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int AVAIL_W = ADDR_W + 3;

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            empty;
  logic            full;
  logic [1:0]      word_sel;
  logic            wr_acc;
  logic            rd_acc;
  logic            rd_pop;
  block_t          mem [DEPTH];
  block_t          head;
  logic [ADDR_W:0] occ;

  // Both operations qualify against pre-edge flags, so a read that frees the
  // last slot does not let a same-edge write in.
  assign wr_acc = bus.write_en && !full;
  assign rd_acc = bus.read_en && !empty;
  assign rd_pop = rd_acc && (word_sel == 2'd3);

  fifo_ptr_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk    (clk),
    .n_rst  (n_rst),
    .wr_inc (wr_acc),
    .rd_inc (rd_pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .empty  (empty),
    .full   (full)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_sel <= 2'd0;
    end else if (rd_acc) begin
      word_sel <= word_sel + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
  end

  assign head = mem[rd_ptr[ADDR_W-1:0]];

  always_comb begin
    bus.data_out = '0;
    if (!empty) begin
      case (word_sel)
        2'd0:    bus.data_out = head[127:96];
        2'd1:    bus.data_out = head[95:64];
        2'd2:    bus.data_out = head[63:32];
        default: bus.data_out = head[31:0];
      endcase
    end
  end

  assign occ             = wr_ptr - rd_ptr;
  assign bus.words_avail = {occ, 2'b00} - AVAIL_W'(word_sel);
  assign bus.fifo_empty  = empty;
  assign bus.fifo_full   = full;

`ifdef FIFO_OUT_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.write_en && full) overflow_q  <= 1'b1;
      if (bus.read_en && empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_out.sv
// Directed bench for fifo_out with a word-queue scoreboard; FIFO_OUT_ERR_EN enables error-flag steps.
module tb_fifo_out;
  import aes_fifo_pkg::*;

  localparam int DEPTH = 2;

  logic tb_clk = 1'b0;
  logic n_rst  = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  word_t sb_q[$];

  fifo_out_if #(.DEPTH(DEPTH)) bus ();

  fifo_out #(.DEPTH(DEPTH)) dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_empty();
    return sb_q.size() == 0;
  endfunction

  // A partially read head entry still occupies its slot.
  function automatic bit m_full();
    return ((sb_q.size() + 3) / 4) == DEPTH;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "/data_out"}, bus.data_out, m_empty() ? 32'h0 : sb_q[0]);
    check({tag, "/empty"}, 32'(bus.fifo_empty), 32'(m_empty()));
    check({tag, "/full"}, 32'(bus.fifo_full), 32'(m_full()));
    check({tag, "/avail"}, 32'(bus.words_avail), 32'(sb_q.size()));
  endtask

  // Called just after a falling edge; applies one rising edge and checks at the next fall.
  task automatic step(input logic we, input block_t din, input logic re, input string tag);
    bit    pre_full;
    bit    pre_empty;
    word_t exp_w;
    pre_full  = m_full();
    pre_empty = m_empty();
    bus.write_en = we;
    bus.data_in  = din;
    bus.read_en  = re;
    if (re && !pre_empty) begin
      exp_w = sb_q.pop_front();
      check({tag, "/pop"}, bus.data_out, exp_w);
    end
    if (we && !pre_full) begin
      for (int k = 0; k < 4; k++) sb_q.push_back(din[127-32*k -: 32]);
    end
    @(posedge tb_clk);
    #1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    @(negedge tb_clk);
    check_state(tag);
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    block_t blk;
    word_t  exp1 [4];
    exp1[0] = 32'h7D8AE0F7;
    exp1[1] = 32'hCFA0A6CB;
    exp1[2] = 32'h09FB5D05;
    exp1[3] = 32'hA8EC586D;

    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.data_in  = '0;

    // Asynchronous reset, observed before any rising edge
    #2 n_rst = 1'b0;
    #1 check_state("reset");
    check("reset/data_out0", bus.data_out, 32'h0);
    @(negedge tb_clk);
    n_rst = 1'b1;

    // Single block
    step(1'b1, 128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D, 1'b0, "wr1");
    check("wr1/head", bus.data_out, exp1[0]);
    check("wr1/avail4", 32'(bus.words_avail), 32'd4);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1, "rd1");
      if (k < 3) check("rd1/next", bus.data_out, exp1[k+1]);
    end
    check("rd1/empty", 32'(bus.fifo_empty), 32'd1);

    // Fill, overfill, drain
    step(1'b1, 128'hdeb0f81341f3503a7cd01e2bc7cdd556, 1'b0, "fillA");
    step(1'b1, 128'hE6FEBF30133874EBCB49226CD36D0D4F, 1'b0, "fillB");
    check("fill/full", 32'(bus.fifo_full), 32'd1);
    check("fill/avail8", 32'(bus.words_avail), 32'd8);
    step(1'b1, 128'h67928dd5470d4a11f0ea4ae7d49b2dd4, 1'b0, "fillC");
    check("fill/first", bus.data_out, 32'hdeb0f813);
    drain(7, "fdrain");
    check("fill/last", bus.data_out, 32'hD36D0D4F);
    drain(1, "fdrain");
    check("fill/empty", 32'(bus.fifo_empty), 32'd1);

    // Simultaneous write+read while full
    step(1'b1, 128'hdeb0f81341f3503a7cd01e2bc7cdd556, 1'b0, "sfA");
    step(1'b1, 128'hE6FEBF30133874EBCB49226CD36D0D4F, 1'b0, "sfB");
    drain(3, "sfrd");
    step(1'b1, 128'h67928dd5470d4a11f0ea4ae7d49b2dd4, 1'b1, "sfboth");
    check("sfboth/full", 32'(bus.fifo_full), 32'd0);
    check("sfboth/avail4", 32'(bus.words_avail), 32'd4);
    check("sfboth/head", bus.data_out, 32'hE6FEBF30);
    drain(4, "sfdrain");

    // Simultaneous write+read while empty
    step(1'b1, 128'h67928dd5470d4a11f0ea4ae7d49b2dd4, 1'b1, "seboth");
    check("seboth/avail4", 32'(bus.words_avail), 32'd4);
    check("seboth/head", bus.data_out, 32'h67928dd5);
    drain(4, "sedrain");

    // Pointer wrap-around
    for (int i = 0; i < 5; i++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, blk, 1'b0, "wrapwr");
      drain(4, "wraprd");
    end

    // Reset mid-drain
    step(1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, "mrwr");
    drain(2, "mrrd");
    #2 n_rst = 1'b0;
    #1 sb_q.delete();
    check_state("mrrst");
    check("mrrst/data_out0", bus.data_out, 32'h0);
    @(negedge tb_clk);
    n_rst = 1'b1;
    step(1'b1, 128'hA5A5A5A5_11112222_33334444_5A5A5A5A, 1'b0, "mrwr2");
    check("mrwr2/head", bus.data_out, 32'hA5A5A5A5);
    drain(4, "mrdrain");

`ifdef FIFO_OUT_ERR_EN
    check("err/ovf0", 32'(bus.overflow), 32'd0);
    check("err/udf0", 32'(bus.underflow), 32'd0);
    step(1'b0, '0, 1'b1, "errudf");
    check("err/udf1", 32'(bus.underflow), 32'd1);
    step(1'b1, 128'h1, 1'b0, "errtr");
    drain(4, "errtr");
    check("err/udf_sticky", 32'(bus.underflow), 32'd1);
    check("err/ovf_still0", 32'(bus.overflow), 32'd0);
    step(1'b1, 128'h2, 1'b0, "errfill");
    step(1'b1, 128'h3, 1'b0, "errfill");
    step(1'b1, 128'h4, 1'b0, "errovf");
    check("err/ovf1", 32'(bus.overflow), 32'd1);
    #2 n_rst = 1'b0;
    #1 sb_q.delete();
    check("err/ovf_rst", 32'(bus.overflow), 32'd0);
    check("err/udf_rst", 32'(bus.underflow), 32'd0);
    @(negedge tb_clk);
    n_rst = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
